uart_rx_fe: RTL
===============

// Module: uart_rx_fe
// PURPOSE
// Parametrised UART receive frame engine: the successor to the fixed 8N1 receive path.
// - Integrates its own oversampling tick generator with a runtime divisor.
// - Supports runtime parity (none/even/odd) and 1 or 2 stop bits.
// - Reports framing and parity errors per frame and overrun as a sticky flag.
// - Delivers bytes over a valid/ready handshake. Sits between the rxd pin and the host/FIFO side of the uart top.
// PARAMETERS
// D_W     8   data bits per frame (5..9)
// B_TICK  16  oversampling ticks per bit (even, >=8)
// DVSR_W  11  width of baud divisor input
// PORTS
// clk          in   1       system clock
// reset_n      in   1       asynchronous active-low reset
// rxd          in   1       serial line, asynchronous to clk, idle high
// dvsr         in   DVSR_W  tick period = dvsr+1 clk cycles
// parity_mode  in   2       00 none, 01 even, 10 odd, 11 treated as none
// stop2        in   1       1 = two stop bits expected
// err_clr      in   1       one-cycle pulse, clears overrun
// out_data     out  D_W     received data, LSB first on line
// out_valid    out  1       out_data/frame_err/parity_err valid
// out_ready    in   1       consumer accepts when out_valid&&out_ready
// frame_err    out  1       a stop bit sampled 0 (qualified by out_valid)
// parity_err   out  1       parity mismatch (qualified by out_valid)
// overrun      out  1       sticky: frame completed while output still full
// busy         out  1       FSM not in IDLE
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - all outputs 0.
//   - 2-flop rxd synchroniser set to 1.
//   - tick counter 0, FSM IDLE.
// - Tick gen: counter increments every clk; when counter>=dvsr it pulses tick for 1 cycle and reloads 0.
//   - dvsr=0 -> tick every cycle.
//   - dvsr change takes effect without glitch beyond one shortened period.
// - FSM advances only on tick cycles; s = sample counter, n = bit counter.
//   - IDLE: rxd_s==0 -> START, s=0. parity_mode and stop2 latched here for the whole frame.
//   - START: at s==B_TICK/2-1:
//     - rxd_s==0 -> DATA, s=0, n=0;
//     - rxd_s==1 -> false start, back to IDLE.
//   - DATA: at s==B_TICK-1:
//     - shift rxd_s into MSB of shift reg (right shift), n++.
//     - after D_W bits -> PARITY if enabled, else STOP.
//   - PARITY: at s==B_TICK-1, sample parity bit.
//     - even: XOR(data,bit) must be 0; odd: must be 1.
//     - -> STOP.
//   - STOP: at s==B_TICK-1 sample stop bit; any 0 sets frame error.
//     - stop2: a second full bit period is sampled the same way.
//     - After the last stop sample: load the output stage, then:
//       - frame error -> BRK (wait for line high);
//       - otherwise -> IDLE.
//   - BRK: stays until rxd_s==1 on a tick, then IDLE. A held-low line (break) yields exactly one frame.
// - Output stage (single register):
//   - Load: out_data, frame_err, parity_err and out_valid=1 are set in the clk cycle after the tick that samples the last stop bit.
//   - Load while out_valid&&!out_ready:
//     - new frame dropped, old data kept;
//     - overrun<=1.
//   - Load in the same cycle as a transfer (out_valid&&out_ready):
//     - new frame loaded, out_valid stays 1;
//     - no overrun.
//   - Transfer without load: out_valid<=0. frame_err and parity_err hold their values but are don't-care while out_valid=0.
//   - out_data and flags are stable while out_valid=1 && !out_ready.
// - overrun is cleared by err_clr. If err_clr and a new overrun occur in the same cycle, set wins.
// - busy=1 in every state except IDLE (BRK counts as busy).
// - Reset asserted mid-frame:
//   - abandons the frame immediately;
//   - drops any pending output;
//   - clears overrun.
// TESTING
// (D_W=8, B_TICK=16, dvsr=2)
// 1. Send 0xA5, parity none, 1 stop -> one out_valid with out_data=0xA5, frame_err=0, parity_err=0, busy back to 0.
// 2. Send 0x3C, even parity, parity bit 0 -> parity_err=0. Same data with parity bit 1 -> parity_err=1, out_data=0x3C.
// 3. Send 0x55 with stop bit 0, then hold rxd low for 40 bit times -> exactly one frame, frame_err=1, busy=1 until rxd high.
// 4. Pulse rxd low for 4 ticks only -> no out_valid; FSM returns to IDLE, busy=0.
// 5. out_ready=0; send 0x11 then 0x22 -> out_data stays 0x11, overrun=1; err_clr pulse -> overrun=0.
// 6. Assert reset_n=0 during DATA bit 3 of 0x81 -> all outputs 0. Release, send 0x81 with stop2=1, odd parity -> out_data=0x81, no errors.

Source files
------------

// File: rtl/uart_rx_fe.sv
// UART receive frame engine: oversampling tick generator, runtime parity/stop configuration,
// per-frame framing/parity error flags, sticky overrun, and a valid/ready output register.
module uart_rx_fe #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16,
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxd,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              err_clr,
  output logic [D_W-1:0]    out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int S_W = $clog2(B_TICK);
  localparam int N_W = $clog2(D_W + 1);

  // Handshake: a word moves on any rising clk edge where out_valid && out_ready. While
  // out_valid is high and out_ready low, out_data/frame_err/parity_err do not change.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state, state_nxt;

  logic              rxd_meta, rxd_s;
  logic [DVSR_W-1:0] tick_cnt;
  logic              tick;
  logic [S_W-1:0]    s;
  logic [N_W-1:0]    n;
  logic [D_W-1:0]    shreg;
  logic [1:0]        par_l;
  logic              stop2_l, stop_idx, fe_acc, par_bit;
  logic              s_mid, s_last, n_last, par_en_l, stop_last;
  logic              fe_now, par_calc, pe_now, load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {rxd_meta, rxd_s} <= 2'b11;
    else          {rxd_meta, rxd_s} <= {rxd, rxd_meta};
  end

  // Comparing with >= keeps a divisor that shrinks mid-period from stretching it.
  assign tick = (tick_cnt >= dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign s_mid     = (s == S_W'(B_TICK/2 - 1));
  assign s_last    = (s == S_W'(B_TICK - 1));
  assign n_last    = (n == N_W'(D_W - 1));
  assign par_en_l  = (par_l == 2'b01) || (par_l == 2'b10);
  assign stop_last = !stop2_l || stop_idx;
  assign fe_now    = fe_acc | ~rxd_s;
  assign par_calc  = (^shreg) ^ par_bit;
  assign pe_now    = (par_l == 2'b01) ? par_calc :
                     (par_l == 2'b10) ? ~par_calc : 1'b0;
  assign load      = tick && (state == STOP) && s_last && stop_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        IDLE:    if (!rxd_s) state_nxt = START;
        START:   if (s_mid) state_nxt = rxd_s ? IDLE : DATA;
        DATA:    if (s_last && n_last) state_nxt = par_en_l ? PARITY : STOP;
        PARITY:  if (s_last) state_nxt = STOP;
        STOP:    if (s_last && stop_last) state_nxt = fe_now ? BRK : IDLE;
        BRK:     if (rxd_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s        <= '0;
      n        <= '0;
      shreg    <= '0;
      par_l    <= 2'b00;
      stop2_l  <= 1'b0;
      stop_idx <= 1'b0;
      fe_acc   <= 1'b0;
      par_bit  <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          s <= '0;
          if (!rxd_s) begin
            par_l   <= parity_mode;
            stop2_l <= stop2;
          end
        end
        START: begin
          if (s_mid) begin
            s        <= '0;
            n        <= '0;
            fe_acc   <= 1'b0;
            stop_idx <= 1'b0;
          end else s <= s + 1'b1;
        end
        DATA: begin
          if (s_last) begin
            s     <= '0;
            shreg <= {rxd_s, shreg[D_W-1:1]};
            n     <= n + 1'b1;
          end else s <= s + 1'b1;
        end
        PARITY: begin
          if (s_last) begin
            s       <= '0;
            par_bit <= rxd_s;
          end else s <= s + 1'b1;
        end
        STOP: begin
          if (s_last) begin
            s        <= '0;
            fe_acc   <= fe_now;
            stop_idx <= 1'b1;
          end else s <= s + 1'b1;
        end
        default: s <= '0;
      endcase
    end
  end

  // A completed frame is dropped only when the held word is not leaving this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else if (load && !(out_valid && !out_ready)) begin
      out_data   <= shreg;
      frame_err  <= fe_now;
      parity_err <= pe_now;
      out_valid  <= 1'b1;
    end else if (!load && out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         overrun <= 1'b0;
    else if (load && out_valid && !out_ready) overrun <= 1'b1;
    else if (err_clr)                     overrun <= 1'b0;
  end

endmodule
